sprite_turn_scheduler: RTL and testbench
========================================

Name: sprite_turn_scheduler

Overview:
Turn-based movement controller for the four player sprites on the board display. It arbitrates button input so only the current player's sprite moves, grants a dice-rolled step budget per turn, and applies one grid step per button press. Position updates are committed only at frame boundaries so the renderer never sees a mid-frame change. Outputs feed the per-sprite hit test and sprite address generation in the VGA top level.

Parameters:
GRID, 20, pixels moved per accepted step
X_MIN, 10, minimum legal sprite centre x
X_MAX, 630, maximum legal sprite centre x
Y_MIN, 10, minimum legal sprite centre y
Y_MAX, 470, maximum legal sprite centre y
MAX_STEPS, 12, clamp applied to roll_value
P0_X / P0_Y, 95 / 85, reset position of player 0
P1_X / P1_Y, 400 / 400, reset position of player 1
P2_X / P2_Y, 510 / 85, reset position of player 2
P3_X / P3_Y, 320 / 200, reset position of player 3

Ports:
clk  in  1  100 MHz system clock; the only clock
reset  in  1  synchronous, active-high reset
frame_end  in  1  one-clk pulse between frames, already synchronised to clk
btn_up / btn_down / btn_left / btn_right  in  1 each  debounced button levels
roll_valid  in  1  one-clk strobe qualifying roll_value
roll_value  in  4  dice result, unsigned
end_turn  in  1  one-clk strobe; forfeit remaining steps
pos_x  out  40  packed sprite centre x, player n at [10n+9:10n]
pos_y  out  40  packed sprite centre y, same packing
active_player  out  2  player whose turn it is
steps_left  out  4  remaining step budget
turn_active  out  1  high in MOVE and COMMIT
turn_done  out  1  one-clk pulse when the turn ends

Behaviour:
- Reset (sampled at clk edge while reset=1): positions = P*_X/P*_Y; active_player=0; steps_left=0; turn_active=0; turn_done=0; state=IDLE; button history registers cleared to 0.
- Press detect: btn_q registered each cycle. press = btn & ~btn_q. Held buttons yield a single press.
- Simultaneous presses: priority up > down > left > right. Lower-priority presses in the same cycle are dropped.
- FSM states: IDLE, MOVE, COMMIT, DONE.
- IDLE: on roll_valid, load steps_left = min(roll_value, MAX_STEPS).
  - Loaded value 0: go to DONE.
  - Otherwise go to MOVE.
  - Presses and end_turn are ignored in IDLE.
- MOVE:
  - end_turn has priority over a press in the same cycle and goes to DONE.
  - Otherwise, on a press, compute target = pos ± GRID on the active player's axis, using 11-bit arithmetic so there is no wrap.
  - Target outside [MIN, MAX]: press ignored, no step consumed, stay in MOVE.
  - Target legal: latch target, go to COMMIT.
- COMMIT:
  - Wait for frame_end. A frame_end in the same cycle the press was accepted does not count; the commit uses the next frame_end sampled in COMMIT.
  - On that frame_end, write the latched target into the active player's slot (visible on pos_x/pos_y the following cycle) and decrement steps_left.
  - If the new steps_left is 0, go to DONE; else go to MOVE.
  - Presses, roll_valid and end_turn are ignored in COMMIT.
- DONE (one cycle): turn_done=1; steps_left=0; active_player increments with wrap 3→0; go to IDLE.
- roll_valid outside IDLE is ignored.
- Non-active players' positions never change after reset.
- Reset mid-COMMIT discards the pending target; positions return to reset values.
- turn_active is registered and tracks state (MOVE or COMMIT) with no extra lag beyond the state register.

Test Plan:
- Reset, roll_value=3, one btn_right press, then frame_end → pos_x[9:0] goes 95→115 the cycle after frame_end; steps_left 3→2; active_player=0.
- Hold btn_down for 500 cycles across 3 frame_end pulses → exactly one step: player 0 y goes 85→105.
- Player 0 at x=95: press btn_left 4 times, each followed by frame_end → x goes 75, 55, 35, 15; with roll 5, the 5th left press (target −5) is rejected, steps_left stays 1 and the state stays MOVE.
- roll_value=2, two legal presses each committed → turn_done pulses once, active_player 0→1, turn_active drops; a subsequent btn_up moves nobody.
- roll_value=15 → steps_left=12. roll_value=0 → immediate turn_done and active_player advances. end_turn together with a press in MOVE → no move, turn ends.
- btn_up and btn_right rising in the same cycle → only y decreases by 20. Reset asserted while in COMMIT → positions restored to reset values, state IDLE, no commit on the next frame_end.

Source files
------------

// File: rtl/sprite_turn_scheduler.sv
// Turn-based movement controller for the four board sprites: dice-granted step
// budget, one grid step per button press, position commits only at frame_end.
module sprite_turn_scheduler #(
  parameter int GRID      = 20,
  parameter int X_MIN     = 10,
  parameter int X_MAX     = 630,
  parameter int Y_MIN     = 10,
  parameter int Y_MAX     = 470,
  parameter int MAX_STEPS = 12,
  parameter int P0_X      = 95,
  parameter int P0_Y      = 85,
  parameter int P1_X      = 400,
  parameter int P1_Y      = 400,
  parameter int P2_X      = 510,
  parameter int P2_Y      = 85,
  parameter int P3_X      = 320,
  parameter int P3_Y      = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_end,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        roll_valid,
  input  logic [3:0]  roll_value,
  input  logic        end_turn,
  output logic [39:0] pos_x,
  output logic [39:0] pos_y,
  output logic [1:0]  active_player,
  output logic [3:0]  steps_left,
  output logic        turn_active,
  output logic        turn_done
);

  typedef enum logic [1:0] {IDLE, MOVE, COMMIT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  btn, btn_q, press;
  logic [9:0]  px [4];
  logic [9:0]  py [4];
  logic [9:0]  cur_x, cur_y;
  logic [10:0] target;
  logic        target_y, in_range, target_ok;
  logic [9:0]  pend;
  logic        pend_y;
  logic [3:0]  roll_clamped;

  assign btn   = {btn_up, btn_down, btn_left, btn_right};
  assign press = btn & ~btn_q;
  assign cur_x = px[active_player];
  assign cur_y = py[active_player];
  assign pos_x = {px[3], px[2], px[1], px[0]};
  assign pos_y = {py[3], py[2], py[1], py[0]};

  assign roll_clamped = (roll_value > 4'(MAX_STEPS)) ? 4'(MAX_STEPS) : roll_value;

  // A step below zero wraps to >= 2028 in 11 bits, so the MAX bound rejects it too.
  always_comb begin
    target   = {1'b0, cur_x} + 11'(GRID);
    target_y = 1'b0;
    if (press[3]) begin
      target   = {1'b0, cur_y} - 11'(GRID);
      target_y = 1'b1;
    end else if (press[2]) begin
      target   = {1'b0, cur_y} + 11'(GRID);
      target_y = 1'b1;
    end else if (press[1]) begin
      target   = {1'b0, cur_x} - 11'(GRID);
    end
    in_range = 1'b0;
    if (target_y)
      in_range = (target >= 11'(Y_MIN)) && (target <= 11'(Y_MAX));
    else
      in_range = (target >= 11'(X_MIN)) && (target <= 11'(X_MAX));
    target_ok = (|press) && in_range;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (roll_valid) state_next = (roll_clamped == 4'd0) ? DONE : MOVE;
      MOVE:   if (end_turn) state_next = DONE;
              else if (target_ok) state_next = COMMIT;
      COMMIT: if (frame_end) state_next = (steps_left == 4'd1) ? DONE : MOVE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      btn_q         <= '0;
      active_player <= '0;
      steps_left    <= '0;
      turn_active   <= 1'b0;
      turn_done     <= 1'b0;
      pend          <= '0;
      pend_y        <= 1'b0;
      px[0] <= 10'(P0_X);  py[0] <= 10'(P0_Y);
      px[1] <= 10'(P1_X);  py[1] <= 10'(P1_Y);
      px[2] <= 10'(P2_X);  py[2] <= 10'(P2_Y);
      px[3] <= 10'(P3_X);  py[3] <= 10'(P3_Y);
    end else begin
      state       <= state_next;
      btn_q       <= btn;
      // Flags follow the next state so they line up with the state register.
      turn_active <= (state_next == MOVE) || (state_next == COMMIT);
      turn_done   <= (state_next == DONE);
      case (state)
        IDLE: if (roll_valid) steps_left <= roll_clamped;
        MOVE: if (!end_turn && target_ok) begin
          pend   <= target[9:0];
          pend_y <= target_y;
        end
        COMMIT: if (frame_end) begin
          if (pend_y) py[active_player] <= pend;
          else        px[active_player] <= pend;
          steps_left <= steps_left - 4'd1;
        end
        DONE: begin
          steps_left    <= '0;
          active_player <= active_player + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_turn_scheduler.sv
// Bench for sprite_turn_scheduler: directed scenarios with literal expectations,
// then random stimulus, all checked every cycle against a turn-level model.
module tb_sprite_turn_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_end = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        roll_valid = 1'b0;
  logic [3:0]  roll_value = '0;
  logic        end_turn = 1'b0;
  logic [39:0] pos_x, pos_y;
  logic [1:0]  active_player;
  logic [3:0]  steps_left;
  logic        turn_active, turn_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sprite_turn_scheduler #(.GRID(20), .MAX_STEPS(12)) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .roll_valid(roll_valid), .roll_value(roll_value), .end_turn(end_turn),
    .pos_x(pos_x), .pos_y(pos_y), .active_player(active_player),
    .steps_left(steps_left), .turn_active(turn_active), .turn_done(turn_done)
  );

  // Turn-level model: board positions, whose turn, budget, and turn phase.
  typedef enum int {M_IDLE, M_MOVE, M_COMMIT, M_DONE} phase_t;
  int     mx [4];
  int     my [4];
  int     m_ap, m_steps, m_tgt;
  bit     m_tgt_y;
  bit [3:0] m_bq;
  phase_t m_phase;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [39:0] pack4(input int v[4]);
    logic [39:0] r;
    for (int i = 0; i < 4; i++) r[10*i +: 10] = 10'(v[i]);
    return r;
  endfunction

  task automatic model_reset();
    mx = '{95, 400, 510, 320};
    my = '{85, 400, 85, 200};
    m_ap = 0; m_steps = 0; m_tgt = 0; m_tgt_y = 0; m_bq = '0; m_phase = M_IDLE;
  endtask

  task automatic model_update();
    bit [3:0] b, p;
    int t;
    bit ty;
    if (reset) begin
      model_reset();
      return;
    end
    b = {btn_up, btn_down, btn_left, btn_right};
    p = b & ~m_bq;
    m_bq = b;
    case (m_phase)
      M_IDLE: if (roll_valid) begin
        m_steps = (roll_value > 12) ? 12 : int'(roll_value);
        m_phase = (m_steps == 0) ? M_DONE : M_MOVE;
      end
      M_MOVE: if (end_turn) m_phase = M_DONE;
      else if (p != 0) begin
        if (p[3])      begin ty = 1; t = my[m_ap] - 20; end
        else if (p[2]) begin ty = 1; t = my[m_ap] + 20; end
        else if (p[1]) begin ty = 0; t = mx[m_ap] - 20; end
        else           begin ty = 0; t = mx[m_ap] + 20; end
        if (ty ? (t >= 10 && t <= 470) : (t >= 10 && t <= 630)) begin
          m_tgt = t; m_tgt_y = ty; m_phase = M_COMMIT;
        end
      end
      M_COMMIT: if (frame_end) begin
        if (m_tgt_y) my[m_ap] = m_tgt; else mx[m_ap] = m_tgt;
        m_steps--;
        m_phase = (m_steps == 0) ? M_DONE : M_MOVE;
      end
      M_DONE: begin
        m_steps = 0; m_ap = (m_ap + 1) % 4; m_phase = M_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic compare();
    check("pos_x", pos_x, pack4(mx));
    check("pos_y", pos_y, pack4(my));
    check("active_player", active_player, m_ap);
    check("steps_left", steps_left, m_steps);
    check("turn_active", turn_active, (m_phase == M_MOVE || m_phase == M_COMMIT));
    check("turn_done", turn_done, (m_phase == M_DONE));
  endtask

  // One clock: DUT and model both consume the current inputs; strobes then drop.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    roll_valid = 0; end_turn = 0; frame_end = 0; reset = 0;
  endtask

  task automatic do_reset();  reset = 1; cycle(); endtask
  task automatic roll(input logic [3:0] v); roll_value = v; roll_valid = 1; cycle(); endtask
  task automatic frame(); frame_end = 1; cycle(); endtask
  task automatic tap(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    cycle();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    cycle();
  endtask

  logic [39:0] rst_x, rst_y;

  initial begin
    rst_x = {10'd320, 10'd510, 10'd400, 10'd95};
    rst_y = {10'd200, 10'd85, 10'd400, 10'd85};
    model_reset();

    // Reset state and one committed right step
    do_reset();
    check("rst_pos_x", pos_x, rst_x);
    check("rst_pos_y", pos_y, rst_y);
    check("rst_active", active_player, 0);
    check("rst_steps", steps_left, 0);
    check("rst_turn_active", turn_active, 0);
    check("rst_turn_done", turn_done, 0);
    roll(3);
    check("roll3_steps", steps_left, 3);
    check("roll3_active", turn_active, 1);
    tap(0, 0, 0, 1);
    check("pre_frame_x", pos_x[9:0], 95);
    frame();
    check("right_x", pos_x[9:0], 115);
    check("right_steps", steps_left, 2);
    check("right_player", active_player, 0);

    // Held button gives a single step
    do_reset();
    roll(5);
    btn_down = 1;
    for (int i = 0; i < 500; i++) begin
      if (i % 150 == 100) frame_end = 1;
      cycle();
    end
    btn_down = 0;
    cycle();
    check("held_y", pos_y[9:0], 105);
    check("held_steps", steps_left, 4);

    // Walk to the left edge; the fifth step is rejected
    do_reset();
    roll(5);
    for (int k = 0; k < 4; k++) begin
      tap(0, 0, 1, 0);
      frame();
      check("left_walk_x", pos_x[9:0], 75 - 20 * k);
    end
    tap(0, 0, 1, 0);
    check("edge_steps", steps_left, 1);
    check("edge_move", turn_active, 1);
    frame();
    check("edge_x", pos_x[9:0], 15);

    // Budget exhausted ends the turn and passes control
    do_reset();
    roll(2);
    tap(0, 0, 0, 1);
    frame();
    tap(0, 0, 0, 1);
    frame();
    check("budget_done", turn_done, 1);
    check("budget_x", pos_x[9:0], 135);
    cycle();
    check("next_player", active_player, 1);
    check("next_inactive", turn_active, 0);
    check("done_one_pulse", turn_done, 0);
    tap(1, 0, 0, 0);
    check("idle_press_y", pos_y, rst_y);

    // Clamp, end_turn priority, zero roll
    do_reset();
    roll(15);
    check("clamp_steps", steps_left, 12);
    end_turn = 1; btn_up = 1;
    cycle();
    btn_up = 0;
    check("forfeit_done", turn_done, 1);
    check("forfeit_y", pos_y[9:0], 85);
    cycle();
    check("forfeit_player", active_player, 1);
    roll(0);
    check("zero_roll_done", turn_done, 1);
    cycle();
    check("zero_roll_player", active_player, 2);

    // Simultaneous up+right: up wins
    do_reset();
    roll(3);
    btn_up = 1; btn_right = 1;
    cycle();
    btn_up = 0; btn_right = 0;
    cycle();
    frame();
    check("prio_y", pos_y[9:0], 65);
    check("prio_x", pos_x[9:0], 95);

    // Reset during COMMIT drops the pending step
    do_reset();
    roll(3);
    tap(0, 0, 0, 1);
    reset = 1; frame_end = 1;
    cycle();
    check("commit_rst_x", pos_x, rst_x);
    check("commit_rst_active", turn_active, 0);
    frame();
    check("commit_rst_after", pos_x[9:0], 95);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_up    = ~btn_up;
      if ($urandom_range(0, 5) == 0) btn_down  = ~btn_down;
      if ($urandom_range(0, 5) == 0) btn_left  = ~btn_left;
      if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
      roll_value = 4'($urandom);
      roll_valid = ($urandom_range(0, 7) == 0);
      end_turn   = ($urandom_range(0, 59) == 0);
      frame_end  = ($urandom_range(0, 5) == 0);
      reset      = ($urandom_range(0, 999) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
